// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding word load/store with a fixed access
// latency, valid/ready on both the request and the response side.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [3:0]            cnt;
  logic                  lat_write;
  logic [31:0]           lat_addr;
  logic [31:0]           lat_wdata;
  logic [3:0]            lat_be;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  addr_err;
  logic                  commit;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  assign word_idx  = lat_addr[DEPTH_LOG2+1:2];
  assign addr_err  = (lat_addr[1:0] != 2'b00) || (lat_addr[31:DEPTH_LOG2+2] != '0);
  assign commit    = (state == WAIT) && (cnt == 4'd0);
  assign req_ready = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid)  state_next = WAIT;
      WAIT:    if (cnt == 4'd0) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, latency countdown and the registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      lat_write  <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_be     <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        cnt       <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        resp_err   <= addr_err;
        resp_rdata <= (!addr_err && !lat_write) ? mem[word_idx] : 32'd0;
      end else if (state == RESP && resp_ready) begin
        resp_err   <= 1'b0;
        resp_rdata <= 32'd0;
      end
    end
  end

  // Storage is deliberately left out of reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (commit && lat_write && !addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) mem[word_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a driver pushes expected responses from
// a word-array reference model, a negedge monitor pops and compares them.
module tb_dmem_responder;

  localparam int LAT = 2;
  localparam int BUDGET = 60;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          accept_cycle;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [0:255];
  int          err_count = 0;
  int          check_count = 0;
  int          cycle = 0;
  int          ready_mode = 0;
  bit          check_rate = 0;
  int          prev_accept = 0;
  bit          in_resp = 0;
  logic [31:0] held_rdata;
  logic        held_err;

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (ready_mode == 1) resp_ready = 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference behaviour: byte-addressed 1 KiB space of 32-bit words.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    bit   accepted = 0;
    int unsigned idx;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    for (int i = 0; i < BUDGET; i++) begin
      if (req_ready) begin
        @(posedge clk);
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) begin
      err_count++;
      check_count++;
      $display("[TB] FAIL accept_timeout: request at %h never accepted", addr);
      req_valid = 1'b0;
      return;
    end
    #1;
    e.accept_cycle = cycle;
    if (check_rate) checkOutput("accept_spacing", 32'(cycle - prev_accept), 32'(LAT + 2));
    prev_accept = cycle;
    e.err   = (addr % 4 != 0) || (addr >= 32'd1024);
    e.rdata = 32'd0;
    if (!e.err) begin
      idx = addr / 4;
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        e.rdata = model[idx];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic settleIdle();
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < BUDGET && !req_ready; i++) @(negedge clk);
  endtask

  // Monitor: compares a fresh response on its first cycle, then checks it holds.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_resp = 0;
    end else if (resp_valid) begin
      if (!in_resp) begin
        in_resp = 1;
        held_rdata = resp_rdata;
        held_err = resp_err;
        if (exp_q.size() == 0) begin
          err_count++;
          check_count++;
          $display("[TB] FAIL unexpected_resp: rdata %h err %b with nothing pending", resp_rdata, resp_err);
        end else begin
          e = exp_q.pop_front();
          checkOutput("resp_rdata", resp_rdata, e.rdata);
          checkOutput("resp_err", 32'(resp_err), 32'(e.err));
          checkOutput("resp_latency", 32'(cycle - e.accept_cycle), 32'(LAT));
        end
      end else begin
        checkOutput("hold_rdata", resp_rdata, held_rdata);
        checkOutput("hold_err", 32'(resp_err), 32'(held_err));
        checkOutput("req_ready_in_resp", 32'(req_ready), 32'd0);
      end
    end else begin
      in_resp = 0;
    end
  end

  initial begin
    bit waited;
    int r;
    int unsigned a;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    req_be = 4'd0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_resp_rdata", resp_rdata, 32'd0);
    checkOutput("reset_resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1, 32'h10, 32'hDEADBEEF, 4'b1111);
    applyStimulus(0, 32'h10, 32'h0, 4'b0000);
    applyStimulus(1, 32'h10, 32'h11223344, 4'b0101);
    applyStimulus(0, 32'h10, 32'h0, 4'b0000);
    applyStimulus(1, 32'h10, 32'hFFFFFFFF, 4'b0000);
    applyStimulus(0, 32'h10, 32'h0, 4'b1111);
    applyStimulus(1, 32'h13, 32'h12345678, 4'b1111);
    applyStimulus(0, 32'h400, 32'h0, 4'b0000);
    applyStimulus(0, 32'h10, 32'h0, 4'b0000);
    applyStimulus(1, 32'h20, 32'h55AA00FF, 4'b1111);
    settleIdle();

    // Backpressure: stores offered while the response is stalled must be ignored.
    ready_mode = 2;
    resp_ready = 1'b0;
    applyStimulus(0, 32'h10, 32'h0, 4'b0000);
    waited = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (resp_valid) begin waited = 1; break; end
    end
    if (!waited) begin
      err_count++;
      check_count++;
      $display("[TB] FAIL bp_resp_timeout: resp_valid never rose");
    end
    for (int i = 0; i < 5; i++) begin
      req_valid = (i % 2 == 0);
      req_write = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'h0BADC0DE;
      req_be    = 4'b1111;
      @(negedge clk);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
      checkOutput("bp_resp_valid", 32'(resp_valid), 32'd1);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    ready_mode = 0;
    applyStimulus(0, 32'h20, 32'h0, 4'b0000);
    settleIdle();

    // Reset before the commit edge drops the pending store.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'hCAFEF00D;
    req_be    = 4'b1111;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("midreset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("midreset_resp_rdata", resp_rdata, 32'd0);
    checkOutput("midreset_resp_err", 32'(resp_err), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 32'h10, 32'h0, 4'b0000);
    settleIdle();

    // Back-to-back loads with resp_ready held high.
    applyStimulus(0, 32'h10, 32'h0, 4'b0000);
    check_rate = 1;
    applyStimulus(0, 32'h20, 32'h0, 4'b0000);
    applyStimulus(0, 32'h10, 32'h0, 4'b0000);
    applyStimulus(0, 32'h20, 32'h0, 4'b0000);
    check_rate = 0;
    settleIdle();

    // Randomized traffic over a small fully-initialized window plus error addresses.
    for (int w = 0; w < 16; w++) applyStimulus(1, 32'(w * 4), $urandom, 4'b1111);
    ready_mode = 1;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 15) * 4;
      if (r == 8) a = a + $urandom_range(1, 3);
      else if (r == 9) a = $urandom_range(1, 32'hFFFFF) << 10;
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    settleIdle();
    ready_mode = 0;
    resp_ready = 1'b1;

    for (int i = 0; i < BUDGET && (exp_q.size() != 0 || resp_valid); i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      err_count++;
      check_count++;
      $display("[TB] FAIL drain: %0d responses never arrived", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RISC core. It is the slave end of the core's load/store path: it accepts one word-wide load or store request through a valid/ready handshake, waits a parameterised access latency, commits or reads the addressed word, and returns a response through a second valid/ready handshake. It has one outstanding request at most and serves as the data-side counterpart to the instruction memory during core bring-up and unit test.

## Interface
- DEPTH_LOG2, 8: log2 of the number of 32-bit words stored; valid byte range is 0 .. 4·2^DEPTH_LOG2 − 1.
- LATENCY, 2: rising edges from request acceptance to `resp_valid` assertion; legal range 1..15.
- clk  in  1  single system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; bit i selects byte [8i+7:8i]; ignored for loads.
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  request was misaligned or out of range.

## Operation
- FSM states are IDLE, WAIT and RESP. `req_ready` = (state == IDLE). `resp_valid` = (state == RESP).
- IDLE: on an edge with `req_valid` high, latch write, addr, wdata and be. Load the latency counter with LATENCY−1 and go to WAIT.
- WAIT: on each edge, if the counter ≠ 0, decrement it. If the counter = 0, perform the access, register `resp_rdata`/`resp_err`, and go to RESP.
- RESP: outputs are held stable. On an edge with `resp_ready` high, go to IDLE and clear `resp_rdata` and `resp_err` to 0.
- Address check: `err` = (addr[1:0] ≠ 0) or (addr[31:DEPTH_LOG2+2] ≠ 0). The word index is addr[DEPTH_LOG2+1:2].
- Store without error: each byte with its `be` bit set is overwritten; the other bytes are preserved. `be` = 0000 is a legal no-op store with `err` = 0.
- Load without error: `resp_rdata` = the stored word.
- Any error: no memory update, `resp_rdata` = 0, `resp_err` = 1.
- Stores return `resp_rdata` = 0.
- Memory array is not reset; contents survive `rst_n` assertion. Power-up contents are undefined (X in simulation).

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE, so `req_ready` = 1
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0
  - latency counter 0, latched request fields 0
- Request accepted at edge N. `resp_valid` rises after edge N+LATENCY. The memory read/write commits at edge N+LATENCY.
- Response accepted at edge M. `req_ready` is high from edge M; the next request is accepted no earlier than edge M+1.
- Peak throughput is one request per LATENCY+2 cycles.
- `req_valid` while `req_ready` = 0 is ignored; no queueing. `resp_ready` outside RESP is ignored.
- Request inputs may change freely after the acceptance edge.
- Reset mid-operation:
  - Reset asserted before the commit edge: the pending request is dropped and the store is not committed.
  - Reset asserted in RESP: the response is lost and the memory already holds the store.
- `resp_ready` held high continuously is legal: the response is consumed on its first cycle.

## Test plan
- Reset, then store 0xDEADBEEF, be = 1111 at 0x10, then load 0x10 → `resp_rdata` = 0xDEADBEEF, `resp_err` = 0. `resp_valid` rises exactly 2 edges after each acceptance. The store response has `resp_rdata` = 0.
- Store 0x11223344 with be = 0101 over 0xDEADBEEF at 0x10, then load → 0xDE22BE44. A be = 0000 store leaves the word unchanged with `resp_err` = 0.
- Error cases with DEPTH_LOG2 = 8:
  - Store at 0x13 → `resp_err` = 1, `resp_rdata` = 0.
  - Load at 0x400 → `resp_err` = 1, `resp_rdata` = 0.
  - A subsequent load at 0x10 still returns 0xDE22BE44.
- Backpressure: hold `resp_ready` low for 5 cycles in RESP while pulsing `req_valid` with a store to 0x20 → `resp_valid` stays 1, `resp_rdata` stays stable, `req_ready` stays 0. A later load at 0x20 shows the store was never taken.
- Reset mid-WAIT: with LATENCY = 4, assert `rst_n` low one edge after accepting a store of 0xCAFEF00D to 0x10 → all outputs take reset values at once. After release, a load at 0x10 returns the old 0xDE22BE44.
- LATENCY = 1, back-to-back loads with `req_valid` and `resp_ready` tied high → accept edges 3 cycles apart. Responses are in order with correct data.
